// File: rtl/dds_phase_accum.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | dds_phase_accum : DDS phase accumulator with FTW/offset handshake,       |
// | tick divider and truncated LUT address. Optional: DDS_PHASE_DITHER_EN.   |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module dds_phase_accum #(
  parameter int ACC_W  = 32,
  parameter int ADDR_W = 12,
  parameter int DIV    = 1
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_enable,
  input  logic [ACC_W-1:0]  i_ftw,
  input  logic [ACC_W-1:0]  i_poff,
  input  logic              i_ftw_valid,
  output logic              o_ftw_ready,
  output logic [ADDR_W-1:0] o_phase,
  output logic              o_phase_valid,
  output logic              o_wrap
);

  localparam int               c_CNT_W    = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [c_CNT_W-1:0] c_DIV_LAST = c_CNT_W'(DIV - 1);

  logic [c_CNT_W-1:0] r_cnt;
  logic [ACC_W-1:0]   r_acc;
  logic [ACC_W-1:0]   r_ftw;
  logic [ACC_W-1:0]   r_poff;
  logic [ACC_W-1:0]   r_pend_ftw;
  logic [ACC_W-1:0]   r_pend_poff;
  logic               r_pend;

  logic               w_tick;
  logic               w_accept;
  logic [ACC_W-1:0]   w_f;
  logic [ACC_W-1:0]   w_p;
  logic [ACC_W:0]     w_sum;
  logic [ACC_W-1:0]   w_acc_n;
  logic [ACC_W-1:0]   w_dither;
  logic [ACC_W-1:0]   w_phase_full;

  assign w_tick      = i_enable && (r_cnt == c_DIV_LAST);
  assign o_ftw_ready = !r_pend && !i_rst;
  assign w_accept    = i_ftw_valid && o_ftw_ready;

  // A pending pair is applied on the tick that consumes it, then becomes active.
  assign w_f     = r_pend ? r_pend_ftw  : r_ftw;
  assign w_p     = r_pend ? r_pend_poff : r_poff;
  assign w_sum   = {1'b0, r_acc} + {1'b0, w_f};
  assign w_acc_n = w_sum[ACC_W-1:0];

`ifdef DDS_PHASE_DITHER_EN
  localparam int          c_DITH_W    = ((ACC_W - ADDR_W) < 16) ? (ACC_W - ADDR_W) : 16;
  localparam logic [15:0] c_LFSR_TAPS = 16'hB400;
  localparam logic [15:0] c_LFSR_SEED = 16'hACE1;

  logic [15:0] r_lfsr;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_lfsr <= c_LFSR_SEED;
    end else if (w_tick) begin
      r_lfsr <= {1'b0, r_lfsr[15:1]} ^ (r_lfsr[0] ? c_LFSR_TAPS : 16'h0000);
    end
  end

  assign w_dither = ACC_W'(r_lfsr[c_DITH_W-1:0]);
`else
  assign w_dither = '0;
`endif

  // Offset and dither only shape the address; carry comes from acc + f alone.
  assign w_phase_full = w_acc_n + w_p + w_dither;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_cnt         <= '0;
      r_acc         <= '0;
      r_ftw         <= '0;
      r_poff        <= '0;
      r_pend_ftw    <= '0;
      r_pend_poff   <= '0;
      r_pend        <= 1'b0;
      o_phase       <= '0;
      o_phase_valid <= 1'b0;
      o_wrap        <= 1'b0;
    end else begin
      o_phase_valid <= 1'b0;
      o_wrap        <= 1'b0;
      if (w_tick) begin
        r_cnt         <= '0;
        r_acc         <= w_acc_n;
        r_ftw         <= w_f;
        r_poff        <= w_p;
        r_pend        <= 1'b0;
        o_phase       <= w_phase_full[ACC_W-1 -: ADDR_W];
        o_phase_valid <= 1'b1;
        o_wrap        <= w_sum[ACC_W];
      end else if (i_enable) begin
        r_cnt <= r_cnt + c_CNT_W'(1);
      end
      // Accept after the tick so a word taken on a tick edge waits for the next tick.
      if (w_accept) begin
        r_pend_ftw  <= i_ftw;
        r_pend_poff <= i_poff;
        r_pend      <= 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_dds_phase_accum.sv
`default_nettype none
// Scoreboard bench for dds_phase_accum: DIV=1 instance checked through an
// expectation queue, DIV=4 instance checked for strobe spacing and step.
module tb_dds_phase_accum;

  logic        clk = 1'b0;
  logic        rst;
  logic        en, fv, en4, fv4;
  logic [31:0] ftw, poff, ftw4, poff4;
  logic        ready, pvalid, wrap;
  logic        ready4, pvalid4, wrap4;
  logic [11:0] phase, phase4;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct packed { logic [11:0] ph; logic wr; } exp_t;
  exp_t exp_q[$];

  always #5 clk = ~clk;

  dds_phase_accum #(.ACC_W(32), .ADDR_W(12), .DIV(1)) dut (
    .i_clk(clk), .i_rst(rst), .i_enable(en), .i_ftw(ftw), .i_poff(poff),
    .i_ftw_valid(fv), .o_ftw_ready(ready), .o_phase(phase),
    .o_phase_valid(pvalid), .o_wrap(wrap)
  );

  dds_phase_accum #(.ACC_W(32), .ADDR_W(12), .DIV(4)) dut4 (
    .i_clk(clk), .i_rst(rst), .i_enable(en4), .i_ftw(ftw4), .i_poff(poff4),
    .i_ftw_valid(fv4), .o_ftw_ready(ready4), .o_phase(phase4),
    .o_phase_valid(pvalid4), .o_wrap(wrap4)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, req, $time);
    end
  endtask

  task automatic push(input logic [11:0] ph, input logic wr);
    exp_t e;
    e.ph = ph;
    e.wr = wr;
    exp_q.push_back(e);
  endtask

  task automatic load(input logic [31:0] f, input logic [31:0] p);
    ftw = f; poff = p; fv = 1'b1;
    @(posedge clk); #1;
    fv = 1'b0;
  endtask

  // Scoreboard monitor for the DIV=1 instance.
  always @(negedge clk) begin
    if (pvalid) begin
      if (exp_q.size() == 0) begin
        check("unexpected_valid", 32'(pvalid), 32'd0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("phase", 32'(phase), 32'(e.ph));
        check("wrap", 32'(wrap), 32'(e.wr));
      end
    end
  end

  // DIV=4 monitor: one strobe every 4 cycles, address stepping by 1.
  int cyc4 = 0, last4 = 0, s4 = 0;
  always @(negedge clk) begin
    cyc4++;
    if (pvalid4) begin
      s4++;
      check("div4_phase", 32'(phase4), 32'(s4));
      check("div4_wrap", 32'(wrap4), 32'd0);
      if (s4 > 1) check("div4_gap", 32'(cyc4 - last4), 32'd4);
      last4 = cyc4;
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; en = 1'b0; fv = 1'b0; ftw = '0; poff = '0;
    en4 = 1'b0; fv4 = 1'b0; ftw4 = '0; poff4 = '0;

    // Reset held 10 cycles
    repeat (10) begin
      @(posedge clk);
      @(negedge clk);
      check("rst_phase", 32'(phase), 32'd0);
      check("rst_valid", 32'(pvalid), 32'd0);
      check("rst_wrap", 32'(wrap), 32'd0);
      check("rst_ready", 32'(ready), 32'd0);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("ready_after_rst", 32'(ready), 32'd1);
    check("ready4_after_rst", 32'(ready4), 32'd1);
    @(posedge clk); #1;

    // Basic ramp: 0x010 step, wrap only on sample 256
    for (int k = 1; k <= 256; k++) begin
      logic [11:0] ph;
      ph = 12'(k * 16);
      push(ph, k == 256);
    end
    load(32'h0100_0000, 32'h0);
    en = 1'b1;
    repeat (256) @(posedge clk);
    #1 en = 1'b0;

    // Back-pressure with ENABLE low
    ftw = 32'h0200_0000; poff = 32'h0; fv = 1'b1;
    @(posedge clk); #1;
    ftw = 32'h0300_0000; poff = 32'h4000_0000;
    @(negedge clk);
    check("bp_ready_after_A", 32'(ready), 32'd0);
    repeat (5) begin
      @(negedge clk);
      check("bp_ready_hold", 32'(ready), 32'd0);
    end
    @(posedge clk); #1;
    push(12'h020, 1'b0);
    push(12'h040, 1'b0);
    push(12'h470, 1'b0);
    push(12'h4A0, 1'b0);
    en = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("bp_ready_return", 32'(ready), 32'd1);
    @(posedge clk); #1;
    fv = 1'b0;
    @(negedge clk);
    check("bp_ready_B_taken", 32'(ready), 32'd0);
    repeat (2) @(posedge clk);
    #1 en = 1'b0;

    // Offset only after a clean reset
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    for (int k = 0; k < 8; k++) push(12'h800, 1'b0);
    load(32'h0, 32'h8000_0000);
    en = 1'b1;
    repeat (8) @(posedge clk);
    #1 en = 1'b0;

    // Freeze mid-ramp
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    for (int k = 1; k <= 5; k++) push(12'(k * 16), 1'b0);
    load(32'h0100_0000, 32'h0);
    en = 1'b1;
    repeat (5) @(posedge clk);
    #1 en = 1'b0;
    @(posedge clk);
    repeat (7) begin
      @(negedge clk);
      check("freeze_valid", 32'(pvalid), 32'd0);
      check("freeze_phase", 32'(phase), 32'h050);
      @(posedge clk);
    end
    #1;
    push(12'h060, 1'b0);
    push(12'h070, 1'b0);
    push(12'h080, 1'b0);
    en = 1'b1;
    repeat (3) @(posedge clk);
    #1 en = 1'b0;

    // Reset with a word pending: word must be discarded
    load(32'h1234_0000, 32'h0567_0000);
    @(negedge clk);
    check("pend_ready", 32'(ready), 32'd0);
    @(posedge clk); #1;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("mrst_phase", 32'(phase), 32'd0);
    check("mrst_valid", 32'(pvalid), 32'd0);
    check("mrst_wrap", 32'(wrap), 32'd0);
    check("mrst_ready", 32'(ready), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("mrst_ready_back", 32'(ready), 32'd1);
    @(posedge clk); #1;
    for (int k = 0; k < 4; k++) push(12'h000, 1'b0);
    en = 1'b1;
    repeat (4) @(posedge clk);
    #1 en = 1'b0;

    // Divider instance, DIV=4
    ftw4 = 32'h0010_0000; poff4 = 32'h0; fv4 = 1'b1;
    @(posedge clk); #1;
    fv4 = 1'b0;
    en4 = 1'b1;
    repeat (40) @(posedge clk);
    #1 en4 = 1'b0;

    repeat (4) @(posedge clk);
    @(negedge clk);
    check("queue_drained", 32'(exp_q.size()), 32'd0);
    check("div4_strobes", 32'(s4), 32'd10);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/dds_phase_accum.md
Name: dds_phase_accum

Overview:
- Phase accumulator stage of the DDS function generator.
- Sits directly downstream of the 27 MHz clock/reset source and upstream of the waveform LUT.
- Advances an ACC_W-bit phase by a frequency tuning word (FTW) on each sample tick. Emits a truncated, offset LUT address with a one-cycle valid strobe and a wrap flag.
- New FTW/phase-offset pairs arrive via a valid/ready handshake and take effect phase-continuously on the next tick.

Parameters:
- ACC_W, 32, accumulator and tuning-word width.
- ADDR_W, 12, LUT address width; PHASE_OUT = top ADDR_W bits. Constraint: ADDR_W < ACC_W.
- DIV, 1, sample-tick divider: one tick every DIV enabled clocks. Constraint: DIV >= 1.

Ports:
- CLK  in  1  system clock (27 MHz).
- RESET  in  1  synchronous, active-high reset.
- ENABLE  in  1  run enable; low freezes divider and accumulator.
- FTW_IN  in  ACC_W  frequency tuning word.
- POFF_IN  in  ACC_W  phase offset, loaded together with FTW_IN.
- FTW_VALID  in  1  FTW_IN/POFF_IN valid.
- FTW_READY  out  1  block can accept a word pair.
- PHASE_OUT  out  ADDR_W  LUT address.
- PHASE_VALID  out  1  one-cycle strobe; PHASE_OUT updated this cycle.
- WRAP  out  1  accumulator overflowed on this sample; coincident with PHASE_VALID.

Behaviour:
- Interface: one clock CLK; RESET is synchronous and active-high.
- Reset: on any edge with RESET=1, the following clear to 0: acc, active FTW, active POFF, pending register, pend flag, divider count, PHASE_OUT, PHASE_VALID, WRAP.
  - FTW_READY = !pend && !RESET (combinational), so it is 0 during reset.
  - Reset mid-operation discards any pending word.
- Divider: cnt counts 0..DIV-1 while ENABLE=1; tick = ENABLE && cnt==DIV-1; cnt wraps to 0 on tick.
  - ENABLE=0: cnt holds, no tick.
  - DIV=1: tick every enabled cycle.
- Handshake:
  - A word pair is accepted on a cycle with FTW_VALID && FTW_READY: pending <= {FTW_IN, POFF_IN}, pend <= 1.
  - While pend=1, FTW_READY=0 and FTW_IN/POFF_IN are ignored.
- Tick cycle:
  - f = pend ? pending FTW : active FTW; p = pend ? pending POFF : active POFF.
  - {carry, acc_n} = acc + f (ACC_W+1 bit, unsigned).
  - Registered on that edge: acc <= acc_n; active <= {f, p}; pend <= 0; PHASE_OUT <= (acc_n + p) mod 2^ACC_W, bits [ACC_W-1 : ACC_W-ADDR_W]; PHASE_VALID <= 1; WRAP <= carry.
  - Latency: outputs valid the cycle after the tick edge. The accumulator is never reset by a word load (phase-continuous).
- Non-tick cycle: PHASE_VALID <= 0, WRAP <= 0, PHASE_OUT holds.
- Simultaneous accept and tick:
  - A word accepted on a tick edge is not used by that tick; it applies at the following tick.
  - If pend=1 on a tick edge, READY was 0 that cycle, so accept and apply can never collide on the same word.
- The offset addition is modulo 2^ACC_W; the offset never affects WRAP.

Optional Feature:
- Macro: DDS_PHASE_DITHER_EN.
- Defined:
  - A 16-bit Galois LFSR (x^16+x^14+x^13+x^11+1, seed 16'hACE1 on reset) advances once per tick.
  - Its low min(16, ACC_W-ADDR_W) bits, zero-extended, are added to (acc_n + p) before truncation.
  - acc and WRAP are unaffected.
- Undefined: no LFSR logic; truncation is exact as above.

Test Plan:
- Reset: hold RESET=1 for 10 cycles -> PHASE_OUT=0, PHASE_VALID=0, WRAP=0, FTW_READY=0; release -> FTW_READY=1 on the first cycle after RESET=0.
- Basic ramp, DIV=1, ENABLE=1: load FTW=32'h0100_0000, POFF=0 -> PHASE_OUT 12'h010, 12'h020, ... on consecutive cycles; the 256th sample shows PHASE_OUT=12'h000 with WRAP=1, no other WRAP.
- Divider, DIV=4, FTW=32'h0010_0000: PHASE_VALID high exactly 1 cycle in 4; PHASE_OUT steps by 12'h001 per strobe.
- Handshake back-pressure, ENABLE=0: present word A -> accepted, FTW_READY=0; present word B for 5 cycles -> not accepted. Raise ENABLE -> first sample uses A, READY returns, B accepted and used on the next tick; no word lost.
- Offset only: FTW=0, POFF=32'h8000_0000 -> PHASE_OUT=12'h800 every strobe, WRAP never asserts.
- Freeze and mid-run reset: ENABLE low for 7 cycles mid-ramp -> PHASE_VALID=0, PHASE_OUT/acc hold, ramp resumes seamlessly; assert RESET with a word pending -> all outputs 0, pending word discarded, next ramp starts at 0 with FTW=0.
